mul_issue_ctrl: RTL

- Sequencer for ARM7 MUL/MLA, placed between the decode/register-read stage and Booth_multiplier.
- Latches the operands, launches the multiplier, and waits out its ready-low/ready-high handshake.
- Adds the accumulator for MLA and computes N/Z when S is set.
- Presents a single writeback beat under a valid/ready handshake, with a timeout guard against a hung multiplier.

---
 rtl/mul_issue_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mul_issue_ctrl.sv
// ARM7 MUL/MLA sequencer: latches operands, drives Booth_multiplier through its ready handshake,
// adds the accumulator, then holds one writeback beat until wb_ready; a hung multiplier aborts to IDLE.
module mul_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        issue_accumulate,
  input  logic        issue_setflags,
  input  logic [3:0]  issue_rd,
  input  logic [31:0] issue_rm,
  input  logic [31:0] issue_rs,
  input  logic [31:0] issue_rn,
  output logic        Multiplier_enable,
  output logic [31:0] Multiplier_A,
  output logic [31:0] Multiplier_B,
  input  logic [31:0] Multiplier_Result,
  input  logic        Multiplier_ready,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_flag_we,
  output logic        wb_flag_n,
  output logic        wb_flag_z,
  output logic        mul_busy,
  output logic        mul_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    ACCUM,
    WRITEBACK
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nxt;
  logic [31:0]          rm_q, rs_q, rn_q, prod_q, res_q;
  logic [3:0]           rd_q;
  logic                 acc_q, s_q, n_q, z_q;
  logic                 timeout_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 cnt_expired;
  logic                 abort;
  logic [31:0]          sum;

  assign cnt_expired = (cnt_q == CNT_LAST);
  assign sum         = prod_q + (acc_q ? rn_q : 32'd0);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Normal progress out of a wait state wins over a coincident timeout.
  always_comb begin
    state_nxt         = state;
    abort             = 1'b0;
    issue_ready       = 1'b0;
    Multiplier_enable = 1'b0;
    wb_valid          = 1'b0;
    mul_busy          = 1'b1;
    case (state)
      IDLE: begin
        issue_ready = 1'b1;
        mul_busy    = 1'b0;
        if (issue_valid) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        Multiplier_enable = 1'b1;
        state_nxt         = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        Multiplier_enable = 1'b1;
        if (!Multiplier_ready) state_nxt = WAIT_DONE;
        else if (cnt_expired) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (Multiplier_ready) state_nxt = ACCUM;
        else if (cnt_expired) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      ACCUM: state_nxt = WRITEBACK;
      WRITEBACK: begin
        wb_valid = 1'b1;
        if (wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rm_q      <= '0;
      rs_q      <= '0;
      rn_q      <= '0;
      rd_q      <= '0;
      acc_q     <= 1'b0;
      s_q       <= 1'b0;
      prod_q    <= '0;
      res_q     <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE && issue_valid) begin
        rm_q  <= issue_rm;
        rs_q  <= issue_rs;
        rn_q  <= issue_rn;
        rd_q  <= issue_rd;
        acc_q <= issue_accumulate;
        s_q   <= issue_setflags;
      end
      if (state == LAUNCH)
        cnt_q <= '0;
      else if (state == WAIT_BUSY || state == WAIT_DONE)
        cnt_q <= cnt_q + 1'b1;
      if (state == WAIT_DONE && Multiplier_ready)
        prod_q <= Multiplier_Result;
      if (state == ACCUM) begin
        res_q <= sum;
        n_q   <= sum[31];
        z_q   <= (sum == 32'd0);
      end
      if (abort)
        timeout_q <= 1'b1;
    end
  end

  assign Multiplier_A = rm_q;
  assign Multiplier_B = rs_q;
  assign wb_rd        = rd_q;
  assign wb_data      = res_q;
  assign wb_flag_we   = s_q;
  assign wb_flag_n    = n_q;
  assign wb_flag_z    = z_q;
  assign mul_timeout  = timeout_q;

endmodule
